// File: rtl/vga_line_fetch_ctrl_if.sv
// Signal bundle between the line-fetch controller, the VGA timing/pixel path
// and the frame-buffer read port.
interface vga_line_fetch_ctrl_if #(
   parameter int PIX_W = 16
);
   logic             fetch_en;
   logic [9:0]       vga_paddr_h;
   logic [9:0]       vga_paddr_v;
   logic             fb_rd_req;
   logic [18:0]      fb_rd_addr;
   logic             fb_rd_ack;
   logic             fb_rd_valid;
   logic [PIX_W-1:0] fb_rd_data;
   logic             vga_de;
   logic [PIX_W-1:0] vga_rgb;
   logic             underflow;
   logic             overrun;

   modport master (
      input  fetch_en, vga_paddr_h, vga_paddr_v, fb_rd_ack, fb_rd_valid, fb_rd_data,
      output fb_rd_req, fb_rd_addr, vga_de, vga_rgb, underflow, overrun
   );

   modport slave (
      output fetch_en, vga_paddr_h, vga_paddr_v, fb_rd_ack, fb_rd_valid, fb_rd_data,
      input  fb_rd_req, fb_rd_addr, vga_de, vga_rgb, underflow, overrun
   );
endinterface

// File: rtl/vga_line_fetch_ctrl.sv
// Prefetches the next video line from the frame buffer in bursts into a
// ping-pong line buffer and streams the current line out with 1-cycle latency.
module vga_line_fetch_ctrl #(
   parameter int H_ACTIVE  = 640,
   parameter int V_ACTIVE  = 480,
   parameter int V_TOTAL   = 525,
   parameter int BURST_LEN = 64,
   parameter int PIX_W     = 16
) (
   input  logic                  vga_pclk,
   input  logic                  sys_rst_n,
   vga_line_fetch_ctrl_if.master bus
);
   localparam int NBURST = H_ACTIVE / BURST_LEN;
   localparam int BI_W   = (NBURST > 1) ? $clog2(NBURST) : 1;
   localparam int BT_W   = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam int IX_W   = $clog2(2 * H_ACTIVE);

   localparam logic [9:0]      H_ACT_C      = 10'(H_ACTIVE);
   localparam logic [9:0]      V_ACT_C      = 10'(V_ACTIVE);
   localparam logic [9:0]      V_LAST_ACT_C = 10'(V_ACTIVE - 1);
   localparam logic [9:0]      V_LAST_C     = 10'(V_TOTAL - 1);
   localparam logic [BI_W-1:0] BI_LAST      = BI_W'(NBURST - 1);
   localparam logic [BT_W-1:0] BT_LAST      = BT_W'(BURST_LEN - 1);
   localparam logic [18:0]     LINE_STRIDE  = 19'(H_ACTIVE);
   localparam logic [18:0]     BURST_STRIDE = 19'(BURST_LEN);
   localparam logic [IX_W-1:0] IX_LINE      = IX_W'(H_ACTIVE);
   localparam logic [IX_W-1:0] IX_BURST     = IX_W'(BURST_LEN);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_DATA} state_e;

   state_e            state_q, state_d;
   logic [BI_W-1:0]   burst_q, burst_d;
   logic [BT_W-1:0]   beat_q, beat_d;
   logic              tgt_bit_q, tgt_bit_d;
   logic [18:0]       base_q, base_d;
   logic [1:0]        ready_q, ready_d;
   logic              overrun_q, overrun_d;
   logic              underflow_q;
   logic              de_q;
   logic [PIX_W-1:0]  rgb_q;

   logic [PIX_W-1:0]  line_mem [0:2*H_ACTIVE-1];

   logic              trigger;
   logic [9:0]        tgt_line;
   logic              beat_wr;
   logic              pix_active;
   logic [IX_W-1:0]   wr_idx;
   logic [IX_W-1:0]   rd_idx;

   always_comb begin
      trigger    = bus.fetch_en && (bus.vga_paddr_h == H_ACT_C) &&
                   ((bus.vga_paddr_v < V_LAST_ACT_C) || (bus.vga_paddr_v == V_LAST_C));
      tgt_line   = (bus.vga_paddr_v == V_LAST_C) ? 10'd0 : bus.vga_paddr_v + 10'd1;
      beat_wr    = (state_q == S_DATA) && bus.fb_rd_valid;
      wr_idx     = (tgt_bit_q ? IX_LINE : '0) + IX_W'(burst_q) * IX_BURST + IX_W'(beat_q);
      pix_active = (bus.vga_paddr_h < H_ACT_C) && (bus.vga_paddr_v < V_ACT_C);
      rd_idx     = (bus.vga_paddr_v[0] ? IX_LINE : '0) + IX_W'(bus.vga_paddr_h);
   end

   // Fetch FSM: one line per trigger, split into NBURST request/data rounds
   always_comb begin
      state_d   = state_q;
      burst_d   = burst_q;
      beat_d    = beat_q;
      tgt_bit_d = tgt_bit_q;
      base_d    = base_q;
      ready_d   = ready_q;
      overrun_d = overrun_q;
      case (state_q)
         S_IDLE: begin
            if (trigger) begin
               state_d              = S_REQ;
               burst_d              = '0;
               beat_d               = '0;
               tgt_bit_d            = tgt_line[0];
               base_d               = 19'(tgt_line) * LINE_STRIDE;
               ready_d[tgt_line[0]] = 1'b0;
            end
         end
         S_REQ: begin
            if (bus.fb_rd_ack) state_d = S_DATA;
         end
         S_DATA: begin
            if (bus.fb_rd_valid) begin
               if (beat_q == BT_LAST) begin
                  beat_d = '0;
                  if (burst_q == BI_LAST) begin
                     state_d            = S_IDLE;
                     burst_d            = '0;
                     ready_d[tgt_bit_q] = 1'b1;
                  end else begin
                     burst_d = burst_q + 1'b1;
                     state_d = S_REQ;
                  end
               end else begin
                  beat_d = beat_q + 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
      // A trigger seen while busy (including the final-beat cycle) is dropped
      if (trigger && (state_q != S_IDLE)) overrun_d = 1'b1;
   end

   always_ff @(posedge vga_pclk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q   <= S_IDLE;
         burst_q   <= '0;
         beat_q    <= '0;
         tgt_bit_q <= 1'b0;
         base_q    <= '0;
         ready_q   <= '0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         burst_q   <= burst_d;
         beat_q    <= beat_d;
         tgt_bit_q <= tgt_bit_d;
         base_q    <= base_d;
         ready_q   <= ready_d;
         overrun_q <= overrun_d;
      end
   end

   always_ff @(posedge vga_pclk) begin
      if (beat_wr) line_mem[wr_idx] <= bus.fb_rd_data;
   end

   // Pixel output stage: one register between counters and de/rgb
   always_ff @(posedge vga_pclk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         de_q        <= 1'b0;
         rgb_q       <= '0;
         underflow_q <= 1'b0;
      end else begin
         de_q <= pix_active;
         if (pix_active && ready_q[bus.vga_paddr_v[0]]) rgb_q <= line_mem[rd_idx];
         else                                          rgb_q <= '0;
         if (pix_active && !ready_q[bus.vga_paddr_v[0]]) underflow_q <= 1'b1;
      end
   end

   assign bus.fb_rd_req  = (state_q == S_REQ);
   assign bus.fb_rd_addr = base_q + 19'(burst_q) * BURST_STRIDE;
   assign bus.vga_de     = de_q;
   assign bus.vga_rgb    = rgb_q;
   assign bus.underflow  = underflow_q;
   assign bus.overrun    = overrun_q;

endmodule

// File: doc/vga_line_fetch_ctrl.md
VGA_LINE_FETCH_CTRL -- requirements
Module: vga_line_fetch_ctrl

Interface
REQ-001 Parameters, one per line (name, default, meaning), SHALL be:
  H_ACTIVE  640  visible pixels per line
  V_ACTIVE  480  visible lines per frame
  V_TOTAL   525  total lines per frame
  BURST_LEN 64   beats per frame-buffer read burst
  PIX_W     16   pixel width, RGB565
REQ-002 Ports, one per line (name, direction, width, meaning), SHALL be:
  vga_pclk      in   1      pixel clock, 25 MHz
  sys_rst_n     in   1      reset
  fetch_en      in   1      enables line fetching
  vga_paddr_h   in   10     horizontal counter from the timing generator
  vga_paddr_v   in   10     vertical counter from the timing generator
  fb_rd_req     out  1      burst read request
  fb_rd_addr    out  19     burst start pixel address
  fb_rd_ack     in   1      request accepted
  fb_rd_valid   in   1      read data beat valid
  fb_rd_data    in   PIX_W  read data beat
  vga_de        out  1      pixel data enable
  vga_rgb       out  PIX_W  pixel output
  underflow     out  1      sticky: pixel requested from an unready line
  overrun       out  1      sticky: fetch trigger while busy
REQ-003 The block SHALL use one clock, vga_pclk; sys_rst_n SHALL be an asynchronous, active-low reset.

Function
REQ-004 The block SHALL hold a ping-pong line buffer of 2 x H_ACTIVE x PIX_W; line L uses buffer L[0].
REQ-005 Fetch trigger SHALL be the cycle with vga_paddr_h == H_ACTIVE and fetch_en=1, for target line T = vga_paddr_v+1 when vga_paddr_v < V_ACTIVE-1, or T = 0 when vga_paddr_v == V_TOTAL-1; there SHALL be no trigger otherwise.
REQ-006 The FSM SHALL have states IDLE, REQ and DATA.
  - IDLE -> REQ on trigger.
  - REQ -> DATA on the cycle fb_rd_ack=1.
  - DATA -> REQ after BURST_LEN valid beats if bursts remain.
  - DATA -> IDLE after the final beat of burst H_ACTIVE/BURST_LEN-1 (burst 9).
REQ-007 fb_rd_req SHALL be 1 exactly while in REQ; fb_rd_addr SHALL equal T*H_ACTIVE + burst_idx*BURST_LEN and stay stable while fb_rd_req=1. An ack in the first REQ cycle SHALL be legal.
REQ-008 In DATA, each fb_rd_valid=1 beat SHALL be written to buffer T[0] at index burst_idx*BURST_LEN + beat_idx. Valid beats outside DATA SHALL be ignored.
REQ-009 line_ready[T[0]] SHALL clear when a fetch for T starts and set on the final beat of that fetch.
REQ-010 A trigger while not in IDLE SHALL be ignored, SHALL set overrun, and the current fetch SHALL continue unaffected.
REQ-011 Output latency SHALL be 1 cycle:
  - vga_de <= (vga_paddr_h < H_ACTIVE) && (vga_paddr_v < V_ACTIVE).
  - vga_rgb <= buffer[v[0]][h] when active and line_ready[v[0]]=1, else 0.
REQ-012 When active and line_ready[v[0]]=0, vga_rgb SHALL be 0 and underflow SHALL set; underflow and overrun SHALL clear only on reset.
REQ-013 fetch_en=0 SHALL block new triggers only; a fetch in progress SHALL complete.
REQ-014 If a burst's beat count and the trigger boundary coincide on the same cycle, the beat SHALL be written first and the trigger then evaluated per REQ-010.

Reset
REQ-015 While sys_rst_n=0, all of the following SHALL be 0: fb_rd_req, fb_rd_addr, vga_de, vga_rgb, underflow, overrun, FSM (IDLE), burst/beat counters, line_ready[1:0]. Buffer contents SHALL be undefined.
REQ-016 Reset asserted mid-fetch SHALL abort the fetch immediately; after release, no request SHALL issue before the next trigger.

Verification
REQ-017 The bench SHALL cover these scenarios:
  - Single burst: v=524, h=640, fetch_en=1, immediate ack, 64 valid beats per burst -> 10 requests at addr 0,64,...,576, then line_ready[0]=1 before v=0.
  - Steady state: ack delayed 5 cycles, continuous frame -> vga_rgb at (h=10, v=3) equals the data word written at addr 3*640+10, 1 cycle after the counter, underflow=0.
  - Underflow: no fb_rd_valid ever -> first active pixel gives vga_rgb=0, vga_de=1, underflow=1 and sticky.
  - Overrun: valid only every 2nd cycle, so fetch exceeds 800 cycles -> next trigger ignored, overrun=1, and the first fetch still ends with 640 beats written.
  - Reset mid-fetch: sys_rst_n low during burst 4 -> fb_rd_req=0 at once, all outputs 0, and the next request addr equals T*640 at the next trigger.
  - fetch_en toggle: fetch_en=0 at h=640 -> no request; fetch_en=0 mid-fetch -> fetch completes.
